// File: rtl/prefix_adder_mw_seq_if.sv
// Request/response bundle for the multi-word adder sequencer.
// Carries the optional ovf signal when PREFIX_ADDER_MW_OVF_EN is defined.
interface prefix_adder_mw_seq_if #(
  parameter int unsigned NWORDS = 4
);
  localparam int unsigned W = 32 * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef PREFIX_ADDER_MW_OVF_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/prefix_adder_mw_seq.sv
// Multi-word add/subtract sequencer: one 32-bit Kogge-Stone adder processes one word per cycle.
// Optional signed-overflow output enabled by PREFIX_ADDER_MW_OVF_EN.
module prefix_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g0, p0, carry;

  assign g0 = a & b;
  assign p0 = a ^ b;

  for (genvar l = 0; l < 5; l++) begin : g_lvl
    localparam int unsigned D = 1 << l;
    logic [31:0] g_in, p_in, g_o, p_o;
    if (l == 0) begin : g_first
      assign g_in = g0;
      assign p_in = p0;
    end else begin : g_next
      assign g_in = g_lvl[l-1].g_o;
      assign p_in = g_lvl[l-1].p_o;
    end
    // Low D bits already span back to bit 0, so their propagate is kept as-is.
    assign g_o = g_in | (p_in & (g_in << D));
    assign p_o = p_in & ((p_in << D) | ((32'd1 << D) - 32'd1));
  end

  assign carry = g_lvl[4].g_o | (g_lvl[4].p_o & {32{cin}});
  assign sum   = p0 ^ {carry[30:0], cin};
  assign cout  = carry[31];
endmodule

module prefix_adder_mw_seq #(
  parameter int unsigned NWORDS = 4,
  parameter int unsigned IDXW   = $clog2(NWORDS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  prefix_adder_mw_seq_if.slave  bus
);
  localparam int unsigned W = 32 * NWORDS;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_sh_q, b_sh_q, res_q, res_d;
  logic [IDXW-1:0]   cnt_q;
  logic              carry_q, cout_q;
  logic [31:0]       add_sum;
  logic              add_cout;
  logic              last_word;
`ifdef PREFIX_ADDER_MW_OVF_EN
  logic              ovf_q;
`endif

  prefix_adder_32bit u_adder (
    .a    (a_sh_q[31:0]),
    .b    (b_sh_q[31:0]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last_word = (cnt_q == IDXW'(NWORDS - 1));

  // Result fills from the top so the LSW lands at bit 0 after NWORDS shifts.
  if (NWORDS == 1) begin : g_res_one
    assign res_d = add_sum;
  end else begin : g_res_multi
    assign res_d = {add_sum, res_q[W-1:32]};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.in_valid) state_d = StRun;
      StRun:   if (last_word)    state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q == StRun) || (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef PREFIX_ADDER_MW_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_sh_q  <= a_sh_q >> 32;
          b_sh_q  <= b_sh_q >> 32;
          res_q   <= res_d;
          carry_q <= add_cout;
          cnt_q   <= cnt_q + IDXW'(1);
          if (last_word) begin
            cout_q <= add_cout;
`ifdef PREFIX_ADDER_MW_OVF_EN
            // Operand MSBs are bit 31 of the shifters while the MSW is in the adder.
            ovf_q  <= (a_sh_q[31] == b_sh_q[31]) && (add_sum[31] != a_sh_q[31]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = res_q;
  assign bus.cout = cout_q;
`ifdef PREFIX_ADDER_MW_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_prefix_adder_mw_seq.sv
// Directed and randomised checks of prefix_adder_mw_seq at NWORDS=4 and NWORDS=1.
module tb_prefix_adder_mw_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prefix_adder_mw_seq_if #(.NWORDS(4)) bus4 ();
  prefix_adder_mw_seq_if #(.NWORDS(1)) bus1 ();

  prefix_adder_mw_seq #(.NWORDS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  prefix_adder_mw_seq #(.NWORDS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [128:0] model4(input logic [127:0] a, b, input logic ci, su);
    return {1'b0, a} + {1'b0, (su ? ~b : b)} + 129'(su ? 1'b1 : ci);
  endfunction

  function automatic logic [32:0] model1(input logic [31:0] a, b, input logic ci, su);
    return {1'b0, a} + {1'b0, (su ? ~b : b)} + 33'(su ? 1'b1 : ci);
  endfunction

  // Full operation on the 4-word DUT; returns at the negedge after the output handshake.
  task automatic op4(input logic [127:0] a, b, input logic ci, su, input int gap,
                     output logic [127:0] s, output logic c, output int lat,
                     output logic rdy_seen);
    int k;
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.cin = ci; bus4.sub = su; bus4.in_valid = 1'b1;
    k = 0;
    while (!bus4.in_ready && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.a = ~a; bus4.b = ~b; bus4.cin = ~ci;
    lat = 0; rdy_seen = 1'b0;
    while (!bus4.out_valid && lat < 50) begin
      rdy_seen |= bus4.in_ready;
      @(negedge clk);
      lat++;
    end
    repeat (gap) begin rdy_seen |= bus4.in_ready; @(negedge clk); end
    s = bus4.sum; c = bus4.cout;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic op1(input logic [31:0] a, b, input logic ci, su, input int gap,
                     output logic [31:0] s, output logic c, output logic ov, output int lat);
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = ci; bus1.sub = su; bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.a = ~a; bus1.b = ~b;
    lat = 0;
    while (!bus1.out_valid && lat < 50) begin @(negedge clk); lat++; end
    repeat (gap) @(negedge clk);
    s = bus1.sum; c = bus1.cout;
`ifdef PREFIX_ADDER_MW_OVF_EN
    ov = bus1.ovf;
`else
    ov = 1'b0;
`endif
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] s4, ra, rb;
    logic [31:0]  s1, qa, qb;
    logic         c, ov, rs, stable, seen, lat_ok, rc, rsu;
    logic [128:0] m4;
    logic [32:0]  m1;
    int           lat, n_out;

    rst = 1'b1;
    bus4.in_valid = 0; bus4.a = '0; bus4.b = '0; bus4.cin = 0; bus4.sub = 0; bus4.out_ready = 0;
    bus1.in_valid = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0; bus1.sub = 0; bus1.out_ready = 0;
    repeat (2) @(negedge clk);
    // Reset must win over a simultaneous accept.
    bus4.in_valid = 1'b1; bus4.a = 128'd9;
    @(negedge clk);
    rst = 1'b0; bus4.in_valid = 1'b0;
    check_eq("rst_in_ready", 129'(bus4.in_ready), 129'd1);
    check_eq("rst_out_valid", 129'(bus4.out_valid), 129'd0);
    check_eq("rst_busy", 129'(bus4.busy), 129'd0);
    check_eq("rst_sum", 129'(bus4.sum), 129'd0);
    check_eq("rst_cout", 129'(bus4.cout), 129'd0);
    check_eq("rst1_in_ready", 129'(bus1.in_ready), 129'd1);
    @(negedge clk);
    check_eq("rst_prio_busy", 129'(bus4.busy), 129'd0);

    op4('1, 128'd1, 1'b0, 1'b0, 2, s4, c, lat, rs);
    check_eq("t1_sum", 129'(s4), 129'd0);
    check_eq("t1_cout", 129'(c), 129'd1);
    check_eq("t1_latency", 129'(lat), 129'd4);
    check_eq("t1_ready_low", 129'(rs), 129'd0);
    check_eq("t1_ready_after", 129'(bus4.in_ready), 129'd1);

    op4(128'd5, 128'd7, 1'b1, 1'b1, 0, s4, c, lat, rs);
    check_eq("sub57_sum", 129'(s4), 129'({{124{1'b1}}, 4'hE}));
    check_eq("sub57_cout", 129'(c), 129'd0);
    op4(128'd7, 128'd5, 1'b0, 1'b1, 0, s4, c, lat, rs);
    check_eq("sub75_sum", 129'(s4), 129'd2);
    check_eq("sub75_cout", 129'(c), 129'd1);

    // Backpressure with input noise while DONE.
    @(negedge clk);
    bus4.a = 128'd10; bus4.b = 128'd20; bus4.cin = 0; bus4.sub = 0; bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 50) begin @(negedge clk); lat++; end
    check_eq("bp_latency", 129'(lat), 129'd4);
    stable = 1'b1;
    repeat (10) begin
      bus4.a = {$urandom, $urandom, $urandom, $urandom};
      bus4.b = {$urandom, $urandom, $urandom, $urandom};
      bus4.in_valid = ~bus4.in_valid;
      @(negedge clk);
      stable &= (bus4.sum == 128'd30) && !bus4.cout && bus4.out_valid && !bus4.in_ready;
    end
    bus4.in_valid = 1'b0;
    check_eq("bp_stable", 129'(stable), 129'd1);
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    check_eq("bp_idle_ready", 129'(bus4.in_ready), 129'd1);
    check_eq("bp_idle_valid", 129'(bus4.out_valid), 129'd0);

    // Reset during the second RUN cycle.
    @(negedge clk);
    bus4.a = '1; bus4.b = 128'd1; bus4.cin = 0; bus4.sub = 0; bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_ready", 129'(bus4.in_ready), 129'd1);
    check_eq("mid_rst_busy", 129'(bus4.busy), 129'd0);
    check_eq("mid_rst_sum", 129'(bus4.sum), 129'd0);
    check_eq("mid_rst_cout", 129'(bus4.cout), 129'd0);
    seen = 1'b0;
    repeat (8) begin seen |= bus4.out_valid; @(negedge clk); end
    check_eq("mid_rst_no_valid", 129'(seen), 129'd0);
    op4(128'd3, 128'd4, 1'b1, 1'b0, 0, s4, c, lat, rs);
    check_eq("post_rst_sum", 129'(s4), 129'd8);
    check_eq("post_rst_cout", 129'(c), 129'd0);

    n_out = 0; lat_ok = 1'b1;
    for (int i = 0; i < 500; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = (i % 7 == 0) ? ra : {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom); rsu = 1'($urandom);
      m4 = model4(ra, rb, rc, rsu);
      op4(ra, rb, rc, rsu, int'($urandom_range(0, 3)), s4, c, lat, rs);
      if (lat < 50) n_out++;
      lat_ok &= (lat == 4) && !rs;
      check_eq("rnd4_sum", 129'(s4), 129'(m4[127:0]));
      check_eq("rnd4_cout", 129'(c), 129'(m4[128]));
    end
    check_eq("rnd4_latency", 129'(lat_ok), 129'd1);
    check_eq("rnd4_count", 129'(n_out), 129'd500);

    op1(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0, s1, c, ov, lat);
    check_eq("w1_latency", 129'(lat), 129'd1);
    check_eq("w1_sum", 129'(s1), 129'd0);
    check_eq("w1_cout", 129'(c), 129'd1);
`ifdef PREFIX_ADDER_MW_OVF_EN
    op1(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 0, s1, c, ov, lat);
    check_eq("ovf_add_pos", 129'(ov), 129'd1);
    op1(32'h8000_0000, 32'd1, 1'b0, 1'b1, 0, s1, c, ov, lat);
    check_eq("ovf_sub_neg", 129'(ov), 129'd1);
    op1(32'd1, 32'd1, 1'b0, 1'b0, 0, s1, c, ov, lat);
    check_eq("ovf_none", 129'(ov), 129'd0);
`endif

    n_out = 0; lat_ok = 1'b1;
    for (int i = 0; i < 500; i++) begin
      qa = $urandom; qb = $urandom;
      rc = 1'($urandom); rsu = 1'($urandom);
      m1 = model1(qa, qb, rc, rsu);
      op1(qa, qb, rc, rsu, int'($urandom_range(0, 3)), s1, c, ov, lat);
      if (lat < 50) n_out++;
      lat_ok &= (lat == 1);
      check_eq("rnd1_sum", 129'(s1), 129'(m1[31:0]));
      check_eq("rnd1_cout", 129'(c), 129'(m1[32]));
`ifdef PREFIX_ADDER_MW_OVF_EN
      check_eq("rnd1_ovf", 129'(ov),
               129'((qa[31] == (rsu ? ~qb[31] : qb[31])) && (m1[31] != qa[31])));
`endif
    end
    check_eq("rnd1_latency", 129'(lat_ok), 129'd1);
    check_eq("rnd1_count", 129'(n_out), 129'd500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
